// File: rtl/pipelined_adder_pkg.sv
// Shared types and helpers for pipelined_adder: the stage-register record,
// segment-width calculation and signed saturation limits.
package pipelined_adder_pkg;

  // Widest operand the stage record can carry; the top refuses larger N.
  localparam int PA_MAX_N = 64;

  typedef struct packed {
    logic                valid;
    logic                sub;
    logic                carry;
    logic                ovf;
    logic                zero;
    logic [PA_MAX_N-1:0] sum;
    logic [PA_MAX_N-1:0] a;
    logic [PA_MAX_N-1:0] b;
  } stage_t;

  function automatic int seg_width(input int n, input int stages);
    if (stages < 1) begin
      return n;
    end else begin
      return n / stages;
    end
  endfunction

  function automatic logic [PA_MAX_N-1:0] sat_max(input int n);
    logic [PA_MAX_N-1:0] v;
    v = '0;
    for (int i = 0; i < n - 1; i++) begin
      v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [PA_MAX_N-1:0] sat_min(input int n);
    logic [PA_MAX_N-1:0] v;
    v = '0;
    v[n-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build the ripple segments.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_adder_seg.sv
// W-bit combinational ripple segment built from full_adder cells.
module pipelined_adder_seg #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] carry_s;

  assign carry_s[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry_s[i]),
      .sum  (sum[i]),
      .cout (carry_s[i+1])
    );
  end

  assign cout = carry_s[W];

endmodule

// File: rtl/pipelined_adder.sv
// N-bit add/subtract split into STAGES registered carry segments with valid/ready flow control.
// Define PIPELINED_ADDER_SAT_EN to clamp signed overflow in the final stage register.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int W    = seg_width(N, STAGES);
  localparam int LAST = STAGES - 1;
  localparam int SDIV = (STAGES < 1) ? 1 : STAGES;

  if ((STAGES < 1) || ((N % SDIV) != 0) || (N > PA_MAX_N)) begin : g_bad_cfg
    $fatal(1, "pipelined_adder: N must be a multiple of STAGES, STAGES >= 1, N <= PA_MAX_N");
  end

`ifdef PIPELINED_ADDER_SAT_EN
  localparam logic [PA_MAX_N-1:0] SMAX = sat_max(N);
  localparam logic [PA_MAX_N-1:0] SMIN = sat_min(N);
`endif

  stage_t stg_r [STAGES];
  stage_t nxt_s [STAGES];
  stage_t entry_s;
  logic   stall_s;
  logic   accept_s;

  // A held output freezes the whole pipe, bubbles included.
  assign stall_s  = stg_r[LAST].valid && !out_ready;
  assign in_ready = !stall_s;
  assign accept_s = in_valid && in_ready;

  // Entry record: subtract inverts B and forces carry-in; idle cycles insert a zeroed bubble.
  always_comb begin
    entry_s = '0;
    if (accept_s) begin
      entry_s.valid    = 1'b1;
      entry_s.sub      = sub;
      entry_s.carry    = sub ? 1'b1 : cin;
      entry_s.a[N-1:0] = a;
      entry_s.b[N-1:0] = sub ? ~b : b;
    end else begin
      entry_s = '0;
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    stage_t       src_l;
    stage_t       nxt_l;
    logic [W-1:0] seg_sum_l;
    logic         seg_cout_l;

    if (s == 0) begin : g_first
      assign src_l = entry_s;
    end else begin : g_next
      assign src_l = stg_r[s-1];
    end

    pipelined_adder_seg #(.W(W)) u_seg (
      .a    (src_l.a[s*W +: W]),
      .b    (src_l.b[s*W +: W]),
      .cin  (src_l.carry),
      .sum  (seg_sum_l),
      .cout (seg_cout_l)
    );

    if (s == LAST) begin : g_final
      logic [N-1:0] raw_l;
      logic [N-1:0] fin_l;
      logic         ovf_l;

      // Final segment: resolve flags and (optionally) clamp before the output register.
      always_comb begin
        nxt_l                = src_l;
        nxt_l.sum[s*W +: W]  = seg_sum_l;
        nxt_l.carry          = seg_cout_l;
        raw_l                = nxt_l.sum[N-1:0];
        ovf_l                = (src_l.a[N-1] == src_l.b[N-1]) && (raw_l[N-1] != src_l.a[N-1]);
`ifdef PIPELINED_ADDER_SAT_EN
        if (ovf_l) begin
          fin_l = src_l.a[N-1] ? SMIN[N-1:0] : SMAX[N-1:0];
        end else begin
          fin_l = raw_l;
        end
`else
        fin_l = raw_l;
`endif
        nxt_l.sum[N-1:0] = fin_l;
        nxt_l.ovf        = ovf_l;
        nxt_l.zero       = src_l.valid && (fin_l == '0);
      end
    end else begin : g_mid
      // Intermediate segment: deposit this slice of the sum and pass the carry on.
      always_comb begin
        nxt_l               = src_l;
        nxt_l.sum[s*W +: W] = seg_sum_l;
        nxt_l.carry         = seg_cout_l;
      end
    end

    assign nxt_s[s] = nxt_l;
  end

  // Stage registers: async flush on reset, hold everything on stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        stg_r[s] <= '0;
      end
    end else if (!stall_s) begin
      for (int s = 0; s < STAGES; s++) begin
        stg_r[s] <= nxt_s[s];
      end
    end
  end

  assign out_valid = stg_r[LAST].valid;
  assign sum       = stg_r[LAST].sum[N-1:0];
  assign cout      = stg_r[LAST].carry;
  assign ovf       = stg_r[LAST].ovf;
  assign zero      = stg_r[LAST].zero;

endmodule
